// File: rtl/median_window.sv
// median_window: 3-tap sliding window with edge replication at frame start/end,
// producing one registered (x[n-1], x[n], x[n+1]) triple per input sample.
module median_window #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a0,
   output logic [WIDTH-1:0] out_a1,
   output logic [WIDTH-1:0] out_a2,
   output logic             out_last,
   output logic [LEN_W-1:0] out_len
);
   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
   state_t state;
   logic [WIDTH-1:0] prev, cur;
   logic [LEN_W-1:0] count;
   logic free, in_fire;
   always_comb begin
      free = !out_valid || out_ready;
      in_ready = (state == IDLE) ? 1'b1 : (state == RUN) ? free : 1'b0;
      in_fire = in_valid && in_ready;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         prev <= '0;
         cur <= '0;
         count <= '0;
         out_valid <= 1'b0;
         out_last <= 1'b0;
         out_a0 <= '0;
         out_a1 <= '0;
         out_a2 <= '0;
         out_len <= '0;
      end else begin
         // A triple loaded below overrides this drain
         if (out_ready) out_valid <= 1'b0;
         case (state)
            IDLE: if (in_fire) begin
               prev <= in_data;
               cur <= in_data;
               count <= LEN_W'(1);
               state <= in_last ? FLUSH : RUN;
            end
            RUN: if (in_fire) begin
               out_a0 <= prev;
               out_a1 <= cur;
               out_a2 <= in_data;
               out_last <= 1'b0;
               out_valid <= 1'b1;
               prev <= cur;
               cur <= in_data;
               count <= (&count) ? count : count + 1'b1;
               if (in_last) state <= FLUSH;
            end
            FLUSH: if (free) begin
               out_a0 <= prev;
               out_a1 <= cur;
               out_a2 <= cur;
               out_last <= 1'b1;
               out_len <= count;
               out_valid <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_median_window.sv
// tb_median_window: directed vector table, stall/reset sequences and random
// frames checked against a frame-level edge-replication model.
module tb_median_window;
   typedef struct packed {
      logic [7:0]  a0;
      logic [7:0]  a1;
      logic [7:0]  a2;
      logic        last;
      logic [15:0] len;
   } beat_t;
   typedef struct {
      logic [7:0] d;
      logic       l;
      beat_t      e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_last;
   logic [7:0]  in_data;
   logic        out_valid, out_ready, out_last;
   logic [7:0]  out_a0, out_a1, out_a2;
   logic [15:0] out_len;

   int n_total = 0;
   int n_pass = 0;
   int rdy_mode = 0;
   int low_cnt = 0;
   logic cnt_en = 1'b0;
   beat_t got[$];
   beat_t exp_q[$];
   vec_t tbl[10];

   median_window #(.WIDTH(8), .LEN_W(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a0(out_a0), .out_a1(out_a1), .out_a2(out_a2),
      .out_last(out_last), .out_len(out_len)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready)
         got.push_back(beat_t'{out_a0, out_a1, out_a2, out_last, out_last ? out_len : 16'd0});
      if (cnt_en && !in_ready) low_cnt++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic [7:0] d, input logic l, input logic [7:0] a0,
                               input logic [7:0] a1, input logic [7:0] a2, input logic el,
                               input logic [15:0] len);
      vec_t v;
      v.d = d;
      v.l = l;
      v.e = beat_t'{a0, a1, a2, el, len};
      return v;
   endfunction

   task automatic send(input logic [7:0] d, input logic l);
      int t = 0;
      in_valid = 1'b1;
      in_data = d;
      in_last = l;
      @(negedge clk);
      while (!in_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) check("in_ready timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic expect_q(input string name);
      int t = 0;
      while (got.size() < exp_q.size() && t < 20000) begin
         @(posedge clk);
         t++;
      end
      repeat (4) @(posedge clk);
      #1;
      check({name, " count"}, 64'(got.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check($sformatf("%s beat %0d", name, i), 64'(got[i]), 64'(exp_q[i]));
      got.delete();
      exp_q.delete();
   endtask

   initial begin
      int lens[6];
      int n;
      logic [7:0] x[$];
      tbl[0] = mk(8'd10,  1'b0, 8'd10,  8'd10,  8'd50,  1'b0, 16'd0);
      tbl[1] = mk(8'd50,  1'b0, 8'd10,  8'd50,  8'd20,  1'b0, 16'd0);
      tbl[2] = mk(8'd20,  1'b0, 8'd50,  8'd20,  8'd40,  1'b0, 16'd0);
      tbl[3] = mk(8'd40,  1'b1, 8'd20,  8'd40,  8'd40,  1'b1, 16'd4);
      tbl[4] = mk(8'd128, 1'b1, 8'd128, 8'd128, 8'd128, 1'b1, 16'd1);
      tbl[5] = mk(8'd7,   1'b0, 8'd7,   8'd7,   8'd9,   1'b0, 16'd0);
      tbl[6] = mk(8'd9,   1'b1, 8'd7,   8'd9,   8'd9,   1'b1, 16'd2);
      tbl[7] = mk(8'd3,   1'b0, 8'd3,   8'd3,   8'd3,   1'b0, 16'd0);
      tbl[8] = mk(8'd3,   1'b0, 8'd3,   8'd3,   8'd200, 1'b0, 16'd0);
      tbl[9] = mk(8'd200, 1'b1, 8'd3,   8'd200, 8'd200, 1'b1, 16'd3);
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = 8'd0;
      in_last = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset outs", {out_valid, out_last, out_a0, out_a1, out_a2, out_len}, 64'd0);
      check("reset in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      // Frames streamed back to back: each frame end costs one in_ready bubble
      cnt_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         exp_q.push_back(tbl[i].e);
         send(tbl[i].d, tbl[i].l);
      end
      in_valid = 1'b0;
      expect_q("table");
      cnt_en = 1'b0;
      check("flush bubbles", 64'(low_cnt), 64'd4);
      fork
         begin
            for (int i = 1; i <= 5; i++) send(8'(i), i == 5);
            in_valid = 1'b0;
         end
         begin
            int t = 0;
            while (got.size() < 2 && t < 200) begin
               @(posedge clk);
               t++;
            end
            #1;
            out_ready = 1'b0;
            for (int c = 0; c < 3; c++) begin
               @(negedge clk);
               check($sformatf("stall hold %0d", c), {out_valid, in_ready, out_a0, out_a1, out_a2},
                     {1'b1, 1'b0, 8'd2, 8'd3, 8'd4});
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      exp_q.push_back(beat_t'{8'd1, 8'd1, 8'd2, 1'b0, 16'd0});
      exp_q.push_back(beat_t'{8'd1, 8'd2, 8'd3, 1'b0, 16'd0});
      exp_q.push_back(beat_t'{8'd2, 8'd3, 8'd4, 1'b0, 16'd0});
      exp_q.push_back(beat_t'{8'd3, 8'd4, 8'd5, 1'b0, 16'd0});
      exp_q.push_back(beat_t'{8'd4, 8'd5, 8'd5, 1'b1, 16'd5});
      expect_q("stall");
      out_ready = 1'b0;
      send(8'd5, 1'b0);
      send(8'd6, 1'b0);
      in_valid = 1'b0;
      #2;
      check("pre-reset triple", {out_valid, out_a0, out_a1, out_a2}, {1'b1, 8'd5, 8'd5, 8'd6});
      rst = 1'b1;
      #1;
      check("async reset", {out_valid, out_last, out_a0, out_a1, out_a2, out_len}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      send(8'd1, 1'b0);
      send(8'd2, 1'b1);
      in_valid = 1'b0;
      exp_q.push_back(beat_t'{8'd1, 8'd1, 8'd2, 1'b0, 16'd0});
      exp_q.push_back(beat_t'{8'd1, 8'd2, 8'd2, 1'b1, 16'd2});
      expect_q("post-reset");
      lens[0] = 1;
      lens[1] = 300;
      for (int f = 2; f < 6; f++) lens[f] = $urandom_range(1, 300);
      rdy_mode = 1;
      for (int f = 0; f < 6; f++) begin
         n = lens[f];
         x.delete();
         for (int i = 0; i < n; i++) x.push_back(8'($urandom_range(0, 255)));
         for (int i = 0; i < n; i++)
            exp_q.push_back(beat_t'{x[i > 0 ? i - 1 : 0], x[i], x[i < n - 1 ? i + 1 : n - 1],
                                    i == n - 1, i == n - 1 ? 16'(n) : 16'd0});
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               in_valid = 1'b0;
               @(posedge clk);
               #1;
            end
            send(x[i], i == n - 1);
         end
         in_valid = 1'b0;
      end
      expect_q("random");
      rdy_mode = 0;
      out_ready = 1'b1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
